// File: rtl/uart_hamming_pkg.sv
// Shared widths and assembler state encoding for the Hamming-decoded UART receive path.
package uart_hamming_pkg;
  localparam int NIBBLE_W   = 4;
  localparam int BYTE_W     = 8;
  localparam int SYNDROME_W = 3;

  typedef enum logic {
    WAIT_LO = 1'b0,
    WAIT_HI = 1'b1
  } asm_state_e;
endpackage

// File: rtl/byte_fifo.sv
// First-word fall-through FIFO of assembled bytes; each entry is {corrected flag, byte}.
module byte_fifo
  import uart_hamming_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ENTRY_W    = BYTE_W + 1,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic [LVL_W-1:0]   level,
  output logic               drop
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               empty, full, pop_ok, push_ok;

  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == LVL_W'(FIFO_DEPTH));
    pop_ok  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok = push && (!full || pop_ok);
    drop    = push && !push_ok;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    head  = empty ? '0 : mem_q[rd_ptr_q];
    level = level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

// File: rtl/rx_byte_assembler.sv
// Pairs decoded nibbles (low first) into bytes, tracks corrections, abandons stale halves.
//   state   | meaning
//   WAIT_LO | idle, next nibble is the low half of a byte
//   WAIT_HI | low half held, waiting for high half; idle timer running
module rx_byte_assembler
  import uart_hamming_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               nib_valid,
  input  logic [NIBBLE_W-1:0]                nib_data,
  input  logic [SYNDROME_W-1:0]              nib_syndrome,
  input  logic                               byte_pop,
  output logic                               byte_ready,
  output logic [BYTE_W-1:0]                  byte_data,
  output logic                               byte_corrected,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               overflow,
  output logic                               timeout,
  output logic [7:0]                         err_count
);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  asm_state_e          state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [NIBBLE_W-1:0] lo_q, lo_d;
  logic                corr_q, corr_d;
  logic                timeout_q, timeout_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          err_q, err_d;
  logic                nib_err, push, drop;
  logic [BYTE_W:0]     push_data, head;
  logic [LVL_W-1:0]    level;

  always_comb begin
    nib_err   = (nib_syndrome != '0);
    state_d   = state_q;
    timer_d   = timer_q;
    lo_d      = lo_q;
    corr_d    = corr_q;
    timeout_d = 1'b0;
    push      = 1'b0;
    push_data = {corr_q | nib_err, nib_data, lo_q};
    err_d     = err_q;

    // Counts every corrected nibble, even ones later dropped or abandoned.
    if (nib_valid && nib_err && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end

    case (state_q)
      WAIT_LO: begin
        if (nib_valid) begin
          lo_d    = nib_data;
          corr_d  = nib_err;
          timer_d = '0;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (nib_valid) begin
          push    = 1'b1;
          state_d = WAIT_LO;
        end else if (timer_q == TMR_LAST) begin
          timeout_d = 1'b1;
          timer_d   = '0;
          state_d   = WAIT_LO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = WAIT_LO;
    endcase

    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_LO;
      timer_q    <= '0;
      lo_q       <= '0;
      corr_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      lo_q       <= lo_d;
      corr_q     <= corr_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (byte_pop),
    .head      (head),
    .level     (level),
    .drop      (drop)
  );

  assign byte_ready     = (level != '0);
  assign byte_data      = head[BYTE_W-1:0];
  assign byte_corrected = head[BYTE_W];
  assign fifo_level     = level;
  assign overflow       = overflow_q;
  assign timeout        = timeout_q;
  assign err_count      = err_q;
endmodule

// File: tb/tb_rx_byte_assembler.sv
// Directed bench for rx_byte_assembler: byte assembly, corrections, timeout, FIFO limits, reset.
module tb_rx_byte_assembler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       nib_valid = 1'b0;
  logic [3:0] nib_data = '0;
  logic [2:0] nib_syndrome = '0;
  logic       byte_pop = 1'b0;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic       byte_corrected;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       timeout;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  rx_byte_assembler #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(1023)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .nib_valid      (nib_valid),
    .nib_data       (nib_data),
    .nib_syndrome   (nib_syndrome),
    .byte_pop       (byte_pop),
    .byte_ready     (byte_ready),
    .byte_data      (byte_data),
    .byte_corrected (byte_corrected),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .timeout        (timeout),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: all drives happen 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_nib(input logic [3:0] d, input logic [2:0] s);
    nib_valid    = 1'b1;
    nib_data     = d;
    nib_syndrome = s;
    step(1);
    nib_valid    = 1'b0;
    nib_data     = '0;
    nib_syndrome = '0;
  endtask

  task automatic pop_one();
    byte_pop = 1'b1;
    step(1);
    byte_pop = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({byte_ready, byte_data, byte_corrected, fifo_level, overflow, timeout, err_count} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b data=%h corr=%b lvl=%0d ovf=%b to=%b err=%0d want all 0",
               byte_ready, byte_data, byte_corrected, fifo_level, overflow, timeout, err_count);
    end
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_basic();
    send_nib(4'h5, 3'd0);
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++; $display("FAIL basic_ready_after_lo got %b want 0", byte_ready);
    end
    send_nib(4'hA, 3'd0);
    checks++;
    if (byte_ready !== 1'b1 || byte_data !== 8'hA5 || fifo_level !== 3'd1 || byte_corrected !== 1'b0) begin
      errors++;
      $display("FAIL basic_byte got rdy=%b data=%h lvl=%0d corr=%b want 1 a5 1 0",
               byte_ready, byte_data, fifo_level, byte_corrected);
    end
    pop_one();
    checks++;
    if (byte_ready !== 1'b0 || byte_data !== 8'h00 || byte_corrected !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL basic_empty got rdy=%b data=%h corr=%b lvl=%0d want 0 00 0 0",
               byte_ready, byte_data, byte_corrected, fifo_level);
    end
  endtask

  task automatic test_corrected();
    send_nib(4'h3, 3'b101);
    send_nib(4'hC, 3'd0);
    checks++;
    if (byte_data !== 8'hC3 || byte_corrected !== 1'b1 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL corrected got data=%h corr=%b err=%0d want c3 1 1", byte_data, byte_corrected, err_count);
    end
    pop_one();
  endtask

  task automatic test_timeout();
    int pulses;
    int first;
    pulses = 0;
    first  = -1;
    send_nib(4'h7, 3'd0);
    for (int i = 1; i <= 1030; i++) begin
      step(1);
      if (timeout === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (pulses != 1 || first != 1023) begin
      errors++; $display("FAIL timeout_pulse got count=%0d at=%0d want 1 at 1023", pulses, first);
    end
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL timeout_level got %0d want 0", fifo_level);
    end
    send_nib(4'h1, 3'd0);
    send_nib(4'h2, 3'd0);
    checks++;
    if (byte_data !== 8'h21 || fifo_level !== 3'd1) begin
      errors++; $display("FAIL timeout_next_byte got data=%h lvl=%0d want 21 1", byte_data, fifo_level);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b;
    for (int i = 0; i < 5; i++) begin
      send_nib(4'(i), 3'd0);
      send_nib(4'h1, 3'd0);
      if (i == 3) begin
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
          errors++; $display("FAIL ovf_fill got lvl=%0d ovf=%b want 4 0", fifo_level, overflow);
        end
      end
    end
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_drop got lvl=%0d ovf=%b want 4 1", fifo_level, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h10 + 8'(i);
      checks++;
      if (byte_data !== exp_b) begin
        errors++; $display("FAIL ovf_pop%0d got %h want %h", i, byte_data, exp_b);
      end
      pop_one();
    end
    pop_one();
    checks++;
    if (fifo_level !== 3'd0 || byte_ready !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL empty_pop got lvl=%0d rdy=%b ovf=%b want 0 0 1", fifo_level, byte_ready, overflow);
    end
    send_nib(4'h7, 3'd0);
    send_nib(4'h7, 3'd0);
    checks++;
    if (fifo_level !== 3'd1 || byte_data !== 8'h77) begin
      errors++; $display("FAIL after_empty_pop got lvl=%0d data=%h want 1 77", fifo_level, byte_data);
    end
    pop_one();
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_b;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_nib(4'(i), 3'd0);
      send_nib(4'h2, 3'd0);
    end
    send_nib(4'h4, 3'd0);
    byte_pop = 1'b1;
    send_nib(4'h2, 3'd0);
    byte_pop = 1'b0;
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0 || byte_data !== 8'h21) begin
      errors++;
      $display("FAIL full_push_pop got lvl=%0d ovf=%b head=%h want 4 0 21", fifo_level, overflow, byte_data);
    end
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h21 + 8'(i);
      checks++;
      if (byte_data !== exp_b) begin
        errors++; $display("FAIL full_pop%0d got %h want %h", i, byte_data, exp_b);
      end
      pop_one();
    end
  endtask

  task automatic test_reset_wait_hi();
    int pulses;
    pulses = 0;
    send_nib(4'hE, 3'b001);
    send_nib(4'hE, 3'd0);
    send_nib(4'h9, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready, byte_data, byte_corrected, fifo_level, overflow, timeout, err_count} !== 23'd0) begin
      errors++;
      $display("FAIL reset_in_hi got rdy=%b data=%h corr=%b lvl=%0d ovf=%b to=%b err=%0d want all 0",
               byte_ready, byte_data, byte_corrected, fifo_level, overflow, timeout, err_count);
    end
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 1030; i++) begin
      step(1);
      if (timeout === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL reset_no_timeout got %0d pulses want 0", pulses);
    end
    send_nib(4'h4, 3'd0);
    send_nib(4'h6, 3'd0);
    checks++;
    if (byte_data !== 8'h64 || fifo_level !== 3'd1) begin
      errors++; $display("FAIL reset_next_byte got data=%h lvl=%0d want 64 1", byte_data, fifo_level);
    end
  endtask

  task automatic test_err_saturate();
    do_reset();
    for (int i = 1; i <= 260; i++) begin
      send_nib(4'h0, 3'b010);
      if (i == 254) begin
        checks++;
        if (err_count !== 8'd254) begin
          errors++; $display("FAIL err_254 got %0d want 254", err_count);
        end
      end
    end
    checks++;
    if (err_count !== 8'd255) begin
      errors++; $display("FAIL err_saturate got %0d want 255", err_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corrected();
    test_timeout();
    test_overflow();
    test_full_pop();
    test_reset_wait_hi();
    test_err_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
